// File: rtl/servisia_uart_pkg.sv
// servisia_uart_pkg: shared TX FSM encoding, register offsets, status bit positions and divisor default
package servisia_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_DIV = 1'b1;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_LEVEL = 3;
  localparam logic [15:0] DIV_RESET_DEF = 16'd433;
endpackage

// File: rtl/servisia_wb_uart_tx_if.sv
// servisia_wb_uart_tx_if: wishbone peripheral bus (adr/dat/we/stb in, rdt/ack out) with master/slave views
interface servisia_wb_uart_tx_if;
  logic wb_adr_i;
  logic [15:0] wb_dat_i;
  logic wb_we_i;
  logic wb_stb_i;
  logic [31:0] wb_rdt_o;
  logic wb_ack_o;
  modport master(output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, input wb_rdt_o, wb_ack_o);
  modport slave(input wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, output wb_rdt_o, wb_ack_o);
endinterface

// File: rtl/servisia_fifo.sv
// servisia_fifo: sync FIFO (clk, rst async high; push/wdata in, pop/rdata out, empty/full/level status)
module servisia_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] wdata,
  input  logic pop,
  output logic [WIDTH-1:0] rdata,
  output logic empty,
  output logic full,
  output logic [LW-1:0] level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0] wptr, rptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[LW-2:0]] <= wdata;
  // pointers carry one extra wrap bit so level distinguishes full from empty
  assign level = wptr - rptr;
  assign rdata = mem[rptr[LW-2:0]];
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
endmodule

// File: rtl/servisia_wb_uart_tx.sv
// servisia_wb_uart_tx: wishbone-fed 8N1 UART transmitter (wb_clk_i, wb_rst_i, bus slave port, tx_o serial out)
module servisia_wb_uart_tx
  import servisia_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET = DIV_RESET_DEF,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  servisia_wb_uart_tx_if.slave bus,
  output logic tx_o
);
  state_t state, n_state;
  logic [15:0] div, cnt, n_cnt;
  logic [7:0] shift, n_shift, fifo_rdata;
  logic [2:0] idx, n_idx;
  logic [LW-1:0] level;
  logic [31:0] status;
  logic pop, push, empty, full, stall, acc;
  // a full FIFO holds off a DATA write until a pop makes room, so no byte is lost
  assign stall = bus.wb_stb_i & bus.wb_we_i & (bus.wb_adr_i == REG_DATA) & full;
  assign acc = bus.wb_stb_i & ~bus.wb_ack_o & ~stall;
  assign push = acc & bus.wb_we_i & (bus.wb_adr_i == REG_DATA);
  assign status = 32'({level, state != IDLE, full, empty});
  servisia_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(push), .wdata(bus.wb_dat_i[7:0]), .pop(pop),
    .rdata(fifo_rdata), .empty(empty), .full(full), .level(level)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      bus.wb_ack_o <= 1'b0;
      bus.wb_rdt_o <= '0;
      div <= DIV_RESET;
    end else begin
      bus.wb_ack_o <= acc;
      if (acc & bus.wb_we_i & (bus.wb_adr_i == REG_DIV)) div <= bus.wb_dat_i;
      if (acc & ~bus.wb_we_i) bus.wb_rdt_o <= bus.wb_adr_i == REG_DIV ? {16'b0, div} : status;
    end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      idx <= '0;
      tx_o <= 1'b1;
    end else begin
      state <= n_state;
      cnt <= n_cnt;
      shift <= n_shift;
      idx <= n_idx;
      tx_o <= n_state == START ? 1'b0 : n_state == DATA ? n_shift[0] : 1'b1;
    end
  // every bit reloads the divisor, so a divisor write never stretches the bit in flight
  always_comb begin
    n_state = state;
    n_cnt = cnt;
    n_shift = shift;
    n_idx = idx;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop = 1'b1;
          n_shift = fifo_rdata;
          n_cnt = div;
          n_state = START;
        end
      START:
        if (cnt == '0) begin
          n_cnt = div;
          n_idx = '0;
          n_state = DATA;
        end else n_cnt = cnt - 16'd1;
      DATA:
        if (cnt == '0) begin
          n_cnt = div;
          n_idx = idx + 3'd1;
          n_shift = shift >> 1;
          n_state = idx == 3'd7 ? STOP : DATA;
        end else n_cnt = cnt - 16'd1;
      STOP:
        if (cnt == '0) begin
          pop = !empty;
          n_shift = empty ? shift : fifo_rdata;
          n_cnt = div;
          n_state = empty ? IDLE : START;
        end else n_cnt = cnt - 16'd1;
      default: n_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_servisia_wb_uart_tx.sv
// tb_servisia_wb_uart_tx: scoreboard bench; frames and reads checked by monitors against a timing model
module tb_servisia_wb_uart_tx;
  import servisia_uart_pkg::*;
  typedef struct {logic [7:0] data; int cyc;} frame_t;
  logic clk, rst, tx;
  int cyc, n_cmp, n_bad;
  bit mon_busy, prev_ack;
  frame_t sbq[$];
  logic [31:0] rq[$];
  int dv_cyc[$];
  int dv_val[$];
  servisia_wb_uart_tx_if bus();
  servisia_wb_uart_tx #(.FIFO_DEPTH(8)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus.slave), .tx_o(tx));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_at(int c);
    int v;
    v = 433;
    foreach (dv_cyc[i]) if (dv_cyc[i] <= c) v = dv_val[i];
    return v;
  endfunction

  function automatic logic [31:0] st(bit e, bit f, bit b, int lvl);
    return (32'(lvl) << 3) | {29'b0, b, f, e};
  endfunction

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.wb_ack_o && lat < 5000);
    if (!bus.wb_ack_o) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: got no ack want ack");
    end
  endtask

  task automatic wb_write(logic adr, logic [15:0] d, bit track, output int lat);
    bus.wb_adr_i = adr; bus.wb_dat_i = d; bus.wb_we_i = 1; bus.wb_stb_i = 1;
    wait_ack(lat);
    if (bus.wb_ack_o) begin
      if (adr == REG_DATA) begin
        if (track) sbq.push_back('{d[7:0], cyc});
      end else begin
        dv_cyc.push_back(cyc);
        dv_val.push_back(int'(d));
      end
    end
    bus.wb_stb_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(logic adr, logic [31:0] exp, output int lat);
    rq.push_back(exp);
    bus.wb_adr_i = adr; bus.wb_we_i = 0; bus.wb_stb_i = 1;
    wait_ack(lat);
    bus.wb_stb_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic put(logic [7:0] b, string name);
    int lat;
    wb_write(REG_DATA, {8'h0, b}, 1, lat);
    chk(name, lat, 1);
  endtask

  task automatic set_div(int d);
    int lat;
    wb_write(REG_DIV, 16'(d), 1, lat);
    chk("div_write_lat", lat, 1);
  endtask

  task automatic rd(logic adr, logic [31:0] exp, string name);
    int lat;
    wb_read(adr, exp, lat);
    chk(name, lat, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sbq.size() != 0 || mon_busy) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 20000) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got frames pending want drained");
    end
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL start_timeout: got tx high want start bit");
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_ack_o) chk("ack_single", {31'b0, prev_ack}, 0);
    prev_ack = bus.wb_ack_o;
    if (bus.wb_ack_o && !bus.wb_we_i) begin
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdt_unexpected: got read ack %0h want none", bus.wb_rdt_o);
      end else chk("rdt", bus.wb_rdt_o, rq.pop_front());
    end
  end

  // frame monitor: a queued byte starts one cycle after its push or right after the previous
  // stop bit, whichever is later; each bit lasts divisor+1 cycles using the divisor in force
  // the cycle before the bit begins
  initial begin
    frame_t f;
    int start, prev_end, fno, dur;
    bit bad, ok;
    logic e;
    prev_end = -100;
    fno = 0;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) continue;
      f = sbq.pop_front();
      mon_busy = 1;
      start = (prev_end + 1 > f.cyc + 1) ? prev_end + 1 : f.cyc + 1;
      ok = 1;
      while (cyc < start) begin
        if (tx !== 1'b1) ok = 0;
        @(negedge clk);
      end
      if (cyc != start) ok = 0;
      chk($sformatf("frame%0d_gap", fno), {31'b0, ok}, 1);
      for (int i = 0; i < 10; i++) begin
        e = i == 0 ? 1'b0 : i == 9 ? 1'b1 : f.data[i-1];
        dur = div_at(cyc - 1) + 1;
        bad = 0;
        for (int d = 0; d < dur; d++) begin
          if (tx !== e) bad = 1;
          if (!(i == 9 && d == dur - 1)) @(negedge clk);
        end
        chk($sformatf("frame%0d_byte%02h_bit%0d", fno, f.data, i), {31'b0, bad ? ~e : e}, {31'b0, e});
      end
      prev_end = cyc;
      fno++;
      mon_busy = 0;
    end
  end

  initial begin
    int lat, maxlat, n, d, acks;
    logic [7:0] b;
    dv_cyc.push_back(0); dv_val.push_back(433);
    rst = 1;
    bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_we_i = 0; bus.wb_stb_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'b0, tx}, 1);
    chk("reset_ack", {31'b0, bus.wb_ack_o}, 0);
    chk("reset_rdt", bus.wb_rdt_o, 0);
    rst = 0;
    @(posedge clk); #1;
    rd(REG_DATA, st(1, 0, 0, 0), "status_lat");
    rd(REG_DIV, 32'd433, "div_lat");
    set_div(3);
    put(8'hA5, "a5_lat");
    wait_idle();
    set_div(3);
    put(8'h3C, "b2b0_lat");
    put(8'h81, "b2b1_lat");
    put(8'h5E, "b2b2_lat");
    rd(REG_DATA, st(0, 0, 1, 2), "b2b_status_lat");
    wait_idle();
    rd(REG_DATA, st(1, 0, 0, 0), "post_status_lat");
    set_div(0);
    maxlat = 0;
    for (int i = 0; i < 12; i++) begin
      wb_write(REG_DATA, 16'($urandom_range(0, 255)), 1, lat);
      if (i == 0) chk("full_first_lat", lat, 1);
      if (lat > maxlat) maxlat = lat;
    end
    chk("full_stall_seen", {31'b0, maxlat > 1}, 1);
    wait_idle();
    set_div(3);
    put(8'hC6, "divchg_lat");
    wait_start();
    repeat (12) begin @(posedge clk); #1; end
    set_div(7);
    wait_idle();
    rd(REG_DIV, 32'd7, "div7_lat");
    set_div(50);
    put(8'h11, "held0_lat");
    put(8'h22, "held1_lat");
    put(8'h33, "held2_lat");
    rq.push_back(st(0, 0, 1, 2));
    bus.wb_adr_i = REG_DATA; bus.wb_we_i = 0; bus.wb_stb_i = 1;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) acks++;
    end
    bus.wb_stb_i = 0;
    @(posedge clk); #1;
    if (bus.wb_ack_o) acks++;
    chk("held_read_acks", acks, 1);
    wait_idle();
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(0, 4);
      set_div(d);
      n = $urandom_range(2, 10);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        wb_write(REG_DATA, {8'h0, b}, 1, lat);
      end
      rd(REG_DIV, 32'(d), "rand_div_lat");
      wait_idle();
    end
    set_div(3);
    wb_write(REG_DATA, 16'h00F0, 0, lat);
    wait_start();
    repeat (6) begin @(posedge clk); #1; end
    #2;
    rst = 1;
    dv_cyc.push_back(cyc); dv_val.push_back(433);
    #1;
    chk("midreset_tx", {31'b0, tx}, 1);
    chk("midreset_ack", {31'b0, bus.wb_ack_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    rd(REG_DATA, st(1, 0, 0, 0), "midreset_status_lat");
    rd(REG_DIV, 32'd433, "midreset_div_lat");
    repeat (20) begin
      @(posedge clk); #1;
      chk("midreset_idle_tx", {31'b0, tx}, 1);
    end
    chk("reads_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
